led_blink_divider: RTL
======================

// Module: led_blink_divider
// PURPOSE
//  Consumer end of the LED-frequency PIO: takes the 26-bit half-period word driven by the PIO
//  output port and produces a square-wave LED drive plus a one-cycle tick per toggle.
//  Sits in the FPGA fabric between the HPS-writable PIO and the board LED. Also exposes a small
//  Avalon-MM slave for HPS readback of live state and a toggle counter.
// PARAMETERS
//  WIDTH           26        width of period_i, shadow register and cycle counter
//  DEFAULT_PERIOD  24999999  shadow reset value (0.5 s half-period at 50 MHz -> 1 Hz blink)
//  MIN_PERIOD      1000      lower clamp applied when LED_BLINK_MIN_CLAMP_EN is defined
//  LED_RESET       1'b0      led_o value after reset
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  period_i   in   WIDTH  requested half-period minus one, in clk cycles (from PIO out_port)
//  enable_i   in   1      1 = run; 0 = counter held at 0, led_o frozen
//  address    in   2      Avalon-MM word address
//  chipselect in   1      Avalon-MM select
//  write_n    in   1      Avalon-MM write strobe, active-low
//  writedata  in   32     Avalon-MM write data
//  readdata   out  32     Avalon-MM read data, combinational from address (zero wait states)
//  led_o      out  1      LED drive, registered
//  tick_o     out  1      one-cycle pulse on each led_o toggle, registered
// BEHAVIOUR
//  Reset (sync, high): shadow=DEFAULT_PERIOD, cnt=0, led_o=LED_RESET, tick_o=0, tog_cnt=0.
//  Count: when enable_i=1, cnt increments each cycle; terminal when cnt >= shadow.
//  Terminal cycle: next cycle cnt=0, led_o inverted, tick_o=1, shadow<=eff(period_i),
//   tog_cnt+1 (32-bit, wraps 0xFFFFFFFF->0). Half-period = shadow+1 cycles; shadow=0 toggles
//   every cycle.
//  Period changes are applied ONLY at terminal count (glitch-free; no partial half-period)
//   or by a RELOAD command; period_i is never sampled mid-count otherwise.
//  enable_i=0: cnt<=0, tick_o=0, led_o and shadow hold. On re-enable, counting restarts from 0.
//  Register map (read): 0 shadow (zero-ext), 1 cnt (zero-ext), 2 tog_cnt, 3 status
//   {30'b0, enable_i, led_o}. Reads have no side effects; chipselect not required for readdata.
//  Write (chipselect & ~write_n): addr 3 only. bit0 CLEAR -> tog_cnt<=0; bit1 RELOAD ->
//   cnt<=0, shadow<=eff(period_i), no toggle, no tick. Writes to addr 0-2 ignored.
//  Simultaneous events: CLEAR with terminal -> tog_cnt=0 (clear wins). RELOAD with terminal ->
//   RELOAD wins (no toggle, no tick). Reset overrides everything.
// CONFIGURATION
//  LED_BLINK_MIN_CLAMP_EN defined: eff(p) = (p < MIN_PERIOD) ? MIN_PERIOD : p, at every shadow
//   load (reset value DEFAULT_PERIOD is not clamped).
//  Undefined: eff(p) = p; any value incl. 0 accepted unmodified.
// STRUCTURE
//  Package led_blink_pkg: register address constants (REG_SHADOW=0, REG_CNT=1, REG_TOGCNT=2,
//   REG_CTRL=3), CTRL bit indices (CTRL_CLEAR=0, CTRL_RELOAD=1), DEFAULT_PERIOD constant.
//  Sub-module led_blink_counter: shadow register, cycle counter, terminal detect, clamp;
//   outputs terminal strobe and cnt/shadow. Top holds led_o, tick_o, tog_cnt, Avalon decode.
// TESTING
//  1 Reset, enable_i=1, period_i=3 -> first toggle after 24999999+1 cycles; after that,
//    led_o toggles every 4 cycles, tick_o high 1 cycle each, tog_cnt increments by 1.
//  2 Run period=9, change period_i to 2 at cnt=4 -> current half-period still 10 cycles,
//    following half-periods 3 cycles; read addr 0 returns 2 only after that terminal.
//  3 period=9, drop enable_i at cnt=5 for 7 cycles -> led_o frozen, addr1 reads 0; re-enable
//    -> next toggle 10 cycles later.
//  4 Write 0x1 to addr 3 on a terminal cycle -> tog_cnt reads 0; write 0x2 with period_i=5
//    mid-count -> cnt=0, no tick, next toggle after 6 cycles.
//  5 Preload tog_cnt to 0xFFFFFFFF via toggles/force -> next toggle reads 0; reset asserted
//    mid-count -> led_o=LED_RESET, addr0 reads 24999999 next cycle.
//  6 With LED_BLINK_MIN_CLAMP_EN: period_i=0 then RELOAD -> addr0 reads 1000; without: reads 0,
//    led_o toggles every cycle.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared constants for the LED blink divider: Avalon register map, CTRL bit positions,
// and the power-on half-period.
package led_blink_pkg;

    localparam logic [1:0] REG_SHADOW = 2'd0;
    localparam logic [1:0] REG_CNT    = 2'd1;
    localparam logic [1:0] REG_TOGCNT = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_RELOAD = 1;

    // 0.5 s half-period at 50 MHz gives a 1 Hz blink
    localparam int unsigned DEFAULT_PERIOD = 24_999_999;

endpackage

// File: rtl/led_blink_counter.sv
// Half-period engine: shadow period register, cycle counter and terminal detect.
// Optional LED_BLINK_MIN_CLAMP_EN raises every shadow load to at least MIN_PERIOD.
module led_blink_counter
    import led_blink_pkg::*;
#(
    parameter int unsigned      WIDTH        = 26,
    parameter logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD),
    parameter int unsigned      MIN_PERIOD   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] period,
    input  logic             enable,
    input  logic             reload,
    output logic             terminal,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] shadow
);

`ifdef LED_BLINK_MIN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] eff_period;
    logic             terminal_hit;

    always_comb begin
        eff_period = (CLAMP_EN && (period < MIN_P)) ? MIN_P : period;
    end

    assign terminal_hit = enable && (cnt_reg >= shadow_reg);

    // A reload in the terminal cycle swallows the toggle.
    assign terminal = terminal_hit && !reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            shadow_reg <= RESET_PERIOD;
        end else if (reload) begin
            cnt_reg    <= '0;
            shadow_reg <= eff_period;
        end else if (!enable) begin
            cnt_reg    <= '0;
        end else if (terminal_hit) begin
            cnt_reg    <= '0;
            shadow_reg <= eff_period;
        end else begin
            cnt_reg    <= cnt_reg + WIDTH'(1);
        end
    end

    assign cnt    = cnt_reg;
    assign shadow = shadow_reg;

endmodule

// File: rtl/led_blink_divider.sv
// LED square-wave generator fed by the PIO half-period word, with Avalon-MM readback/control.
// Define LED_BLINK_MIN_CLAMP_EN to clamp loaded half-periods to MIN_PERIOD.
module led_blink_divider #(
    parameter int unsigned      WIDTH          = 26,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(led_blink_pkg::DEFAULT_PERIOD),
    parameter int unsigned      MIN_PERIOD     = 1000,
    parameter logic             LED_RESET      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] period_i,
    input  logic             enable_i,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             led_o,
    output logic             tick_o
);

    import led_blink_pkg::*;

    logic             ctrl_write;
    logic             clear_cmd;
    logic             reload_cmd;
    logic             terminal;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic             led_reg;
    logic             tick_reg;
    logic [31:0]      tog_cnt_reg;
    logic             unused_writedata;

    assign ctrl_write = chipselect && !write_n && (address == REG_CTRL);
    assign clear_cmd  = ctrl_write && writedata[CTRL_CLEAR];
    assign reload_cmd = ctrl_write && writedata[CTRL_RELOAD];
    assign unused_writedata = ^writedata[31:2];

    led_blink_counter #(
        .WIDTH        (WIDTH),
        .RESET_PERIOD (DEFAULT_PERIOD),
        .MIN_PERIOD   (MIN_PERIOD)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .period   (period_i),
        .enable   (enable_i),
        .reload   (reload_cmd),
        .terminal (terminal),
        .cnt      (cnt),
        .shadow   (shadow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg     <= LED_RESET;
            tick_reg    <= 1'b0;
            tog_cnt_reg <= '0;
        end else begin
            tick_reg <= terminal;
            if (terminal) begin
                led_reg <= ~led_reg;
            end
            // Clear takes priority over a coincident toggle count.
            if (clear_cmd) begin
                tog_cnt_reg <= '0;
            end else if (terminal) begin
                tog_cnt_reg <= tog_cnt_reg + 32'd1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_SHADOW: readdata = 32'(shadow);
            REG_CNT:    readdata = 32'(cnt);
            REG_TOGCNT: readdata = tog_cnt_reg;
            REG_CTRL:   readdata = {30'b0, enable_i, led_reg};
            default:    readdata = '0;
        endcase
    end

    assign led_o  = led_reg;
    assign tick_o = tick_reg;

endmodule
